vector_max_sub_stage: RTL and testbench

VECTOR_MAX_SUB_STAGE -- requirements
Module: vector_max_sub_stage

---
 rtl/vector_max_sub_stage.sv | 238 +++++++++++++++++++++++
 tb/tb_vector_max_sub_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_max_sub_stage.sv
// vector_max_sub_stage
//   Buffers one vector of signed multi-lane stream beats while tracking the
//   maximum over all kept lanes and the number of kept elements. Once the
//   vector is complete (last beat, or DEPTH beats reached) the stored beats
//   are replayed in order with every kept lane replaced by (x - max),
//   saturated to the most negative value. Unkept lanes replay as the most
//   negative value.
//
// Ports
//   axi_clock_i        : clock, rising edge
//   axi_reset_n_i      : asynchronous active-low reset
//   s_axis_valid_i     : input beat valid
//   s_axis_ready_o     : input beat ready (1 while loading)
//   s_axis_data_i      : LANES x DATA_SIZE input lanes, lane k at [k*DATA_SIZE +: DATA_SIZE]
//   s_axis_keep_i      : per-lane keep
//   s_axis_last_i      : final beat of the vector
//   m_axis_ready_i     : downstream ready
//   m_axis_valid_o     : output beat valid
//   m_axis_data_o      : per-lane x - max
//   m_axis_keep_o      : keep of the replayed beat
//   m_axis_last_o      : final output beat
//   number_of_data_o   : kept elements in the current vector
//   overflow_o         : one-cycle pulse when a vector is truncated at DEPTH beats
module vector_max_sub_stage #(
  parameter int DATA_SIZE = 16,
  parameter int LANES     = 2,
  parameter int DEPTH     = 128
) (
  input  logic                                axi_clock_i,
  input  logic                                axi_reset_n_i,
  input  logic                                s_axis_valid_i,
  output logic                                s_axis_ready_o,
  input  logic [LANES*DATA_SIZE-1:0]          s_axis_data_i,
  input  logic [LANES-1:0]                    s_axis_keep_i,
  input  logic                                s_axis_last_i,
  input  logic                                m_axis_ready_i,
  output logic                                m_axis_valid_o,
  output logic [LANES*DATA_SIZE-1:0]          m_axis_data_o,
  output logic [LANES-1:0]                    m_axis_keep_o,
  output logic                                m_axis_last_o,
  output logic [$clog2(DEPTH*LANES):0]        number_of_data_o,
  output logic                                overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH*LANES) + 1;
  localparam int W  = LANES * DATA_SIZE;

  // Pointers carry one extra bit so a full buffer (DEPTH beats) is representable.
  typedef logic [AW:0] ptr_t;
  typedef enum logic [0:0] {LOAD = 1'b0, DRAIN = 1'b1} state_t;

  localparam logic [DATA_SIZE-1:0] MOST_NEG  = {1'b1, {(DATA_SIZE-1){1'b0}}};
  localparam ptr_t                 PTR_ONE   = ptr_t'(1);
  localparam ptr_t                 LAST_ADDR = ptr_t'(DEPTH - 1);

  // Number of set keep bits in one beat.
  function automatic logic [CW-1:0] popcount(input logic [LANES-1:0] k);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) begin
      n = n + CW'(k[i]);
    end
    return n;
  endfunction

  // Running max updated with the kept lanes of one beat.
  function automatic logic [DATA_SIZE-1:0] beat_max(input logic [W-1:0] d,
                                                    input logic [LANES-1:0] k,
                                                    input logic [DATA_SIZE-1:0] cur);
    logic signed [DATA_SIZE-1:0] m;
    logic signed [DATA_SIZE-1:0] x;
    m = cur;
    for (int i = 0; i < LANES; i++) begin
      x = d[i*DATA_SIZE +: DATA_SIZE];
      if (k[i] && (x > m)) begin
        m = x;
      end
    end
    return m;
  endfunction

  // x - max at one extra bit; anything below the most negative value clamps.
  function automatic logic [DATA_SIZE-1:0] sub_sat(input logic [DATA_SIZE-1:0] x,
                                                   input logic [DATA_SIZE-1:0] m);
    logic [DATA_SIZE:0] d;
    d = {x[DATA_SIZE-1], x} - {m[DATA_SIZE-1], m};
    if (d[DATA_SIZE] && !d[DATA_SIZE-1]) begin
      return MOST_NEG;
    end else begin
      return d[DATA_SIZE-1:0];
    end
  endfunction

  state_t                 state;
  ptr_t                   wr_ptr;
  ptr_t                   rd_ptr;
  logic [DATA_SIZE-1:0]   max_val;
  logic [CW-1:0]          count;

  logic [W-1:0]           mem_data [DEPTH];
  logic [LANES-1:0]       mem_keep [DEPTH];

  logic                   s1_valid;
  logic [W-1:0]           s1_data;
  logic [LANES-1:0]       s1_keep;
  logic                   s1_last;

  logic                   accept;
  logic                   full_beat;
  logic                   end_of_vec;
  logic                   out_done;
  logic                   s2_adv;
  logic                   s1_adv;
  logic                   issue;
  logic [W-1:0]           out_data;

  assign number_of_data_o = count;

  // Handshake and pipeline-advance decode.
  always_comb begin
    accept     = s_axis_valid_i && s_axis_ready_o;
    full_beat  = (wr_ptr == LAST_ADDR);
    end_of_vec = accept && (s_axis_last_i || full_beat);
    out_done   = m_axis_valid_o && m_axis_ready_i && m_axis_last_o;
    s2_adv     = !m_axis_valid_o || m_axis_ready_i;
    s1_adv     = !s1_valid || s2_adv;
    issue      = (state == DRAIN) && (rd_ptr != wr_ptr) && s1_adv;
  end

  // Per-lane subtraction of the vector max for the beat in the read stage.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s1_keep[i]) begin
        out_data[i*DATA_SIZE +: DATA_SIZE] = sub_sat(s1_data[i*DATA_SIZE +: DATA_SIZE], max_val);
      end else begin
        out_data[i*DATA_SIZE +: DATA_SIZE] = MOST_NEG;
      end
    end
  end

  // Beat buffer; contents need no reset because only written entries are replayed.
  always_ff @(posedge axi_clock_i) begin
    if (accept) begin
      mem_data[wr_ptr[AW-1:0]] <= s_axis_data_i;
      mem_keep[wr_ptr[AW-1:0]] <= s_axis_keep_i;
    end
  end

  // LOAD/DRAIN control: write pointer, running max, element count, overflow pulse.
  always_ff @(posedge axi_clock_i or negedge axi_reset_n_i) begin
    if (!axi_reset_n_i) begin
      state          <= LOAD;
      s_axis_ready_o <= 1'b1;
      wr_ptr         <= '0;
      max_val        <= MOST_NEG;
      count          <= '0;
      overflow_o     <= 1'b0;
    end else begin
      overflow_o <= 1'b0;
      case (state)
        LOAD: begin
          if (accept) begin
            wr_ptr  <= wr_ptr + PTR_ONE;
            max_val <= beat_max(s_axis_data_i, s_axis_keep_i, max_val);
            count   <= count + popcount(s_axis_keep_i);
            if (end_of_vec) begin
              state          <= DRAIN;
              s_axis_ready_o <= 1'b0;
              overflow_o     <= !s_axis_last_i;
            end
          end
        end
        DRAIN: begin
          // Ready reasserts together with the LOAD state, so no dead cycle.
          if (out_done) begin
            state          <= LOAD;
            s_axis_ready_o <= 1'b1;
            wr_ptr         <= '0;
            max_val        <= MOST_NEG;
            count          <= '0;
          end
        end
        default: begin
          state          <= LOAD;
          s_axis_ready_o <= 1'b1;
          wr_ptr         <= '0;
          max_val        <= MOST_NEG;
          count          <= '0;
        end
      endcase
    end
  end

  // Two-stage replay pipeline: buffer read stage, then registered output stage.
  always_ff @(posedge axi_clock_i or negedge axi_reset_n_i) begin
    if (!axi_reset_n_i) begin
      rd_ptr         <= '0;
      s1_valid       <= 1'b0;
      s1_data        <= '0;
      s1_keep        <= '0;
      s1_last        <= 1'b0;
      m_axis_valid_o <= 1'b0;
      m_axis_data_o  <= '0;
      m_axis_keep_o  <= '0;
      m_axis_last_o  <= 1'b0;
    end else begin
      if (out_done) begin
        rd_ptr <= '0;
      end else if (issue) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end

      if (issue) begin
        s1_valid <= 1'b1;
        s1_data  <= mem_data[rd_ptr[AW-1:0]];
        s1_keep  <= mem_keep[rd_ptr[AW-1:0]];
        s1_last  <= ((rd_ptr + PTR_ONE) == wr_ptr);
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end

      // Output stage only moves when empty or accepted, so a stalled beat holds.
      if (s2_adv) begin
        m_axis_valid_o <= s1_valid;
        if (s1_valid) begin
          m_axis_data_o <= out_data;
          m_axis_keep_o <= s1_keep;
          m_axis_last_o <= s1_last;
        end else begin
          m_axis_last_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_max_sub_stage.sv
module tb_vector_max_sub_stage;

  localparam int DS = 16;
  localparam int LN = 2;
  localparam int DP = 128;
  localparam int CW = $clog2(DP*LN) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [LN*DS-1:0]  s_data = '0;
  logic [LN-1:0]     s_keep = '0;
  logic              s_last = 1'b0;
  logic              m_ready = 1'b1;
  logic              m_valid;
  logic [LN*DS-1:0]  m_data;
  logic [LN-1:0]     m_keep;
  logic              m_last;
  logic [CW-1:0]     n_data;
  logic              ovf;

  int checks = 0;
  int errors = 0;
  int ov_seen = 0;
  int exp_count = 0;

  logic [31:0] vd[$];
  logic [1:0]  vk[$];
  logic [31:0] ed[$];
  logic [1:0]  ek[$];
  bit          el[$];

  vector_max_sub_stage #(.DATA_SIZE(DS), .LANES(LN), .DEPTH(DP)) dut (
    .axi_clock_i      (clk),
    .axi_reset_n_i    (rst_n),
    .s_axis_valid_i   (s_valid),
    .s_axis_ready_o   (s_ready),
    .s_axis_data_i    (s_data),
    .s_axis_keep_i    (s_keep),
    .s_axis_last_i    (s_last),
    .m_axis_ready_i   (m_ready),
    .m_axis_valid_o   (m_valid),
    .m_axis_data_o    (m_data),
    .m_axis_keep_o    (m_keep),
    .m_axis_last_o    (m_last),
    .number_of_data_o (n_data),
    .overflow_o       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: max over kept lanes as plain integers, then clamp x-max.
  task automatic build_expected();
    int mx;
    int v;
    int r;
    logic [31:0] o;
    mx = -32768;
    exp_count = 0;
    ed.delete(); ek.delete(); el.delete();
    foreach (vd[i]) begin
      for (int l = 0; l < LN; l++) begin
        if (vk[i][l]) begin
          v = $signed(vd[i][l*DS +: DS]);
          exp_count++;
          if (v > mx) mx = v;
        end
      end
    end
    foreach (vd[i]) begin
      o = '0;
      for (int l = 0; l < LN; l++) begin
        if (vk[i][l]) begin
          v = $signed(vd[i][l*DS +: DS]);
          r = v - mx;
          if (r < -32768) r = -32768;
          o[l*DS +: DS] = r[15:0];
        end else begin
          o[l*DS +: DS] = 16'h8000;
        end
      end
      ed.push_back(o);
      ek.push_back(vk[i]);
      el.push_back(i == vd.size() - 1);
    end
  endtask

  task automatic send_vector(input bit with_last);
    int guard;
    for (int i = 0; i < vd.size(); i++) begin
      @(negedge clk);
      if (ovf) ov_seen++;
      s_valid = 1'b1;
      s_data  = vd[i];
      s_keep  = vk[i];
      s_last  = with_last && (i == vd.size() - 1);
      guard = 0;
      while (!s_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard == 50) check("s_ready_timeout", 64'(s_ready), 64'd1);
      @(posedge clk);
    end
    @(negedge clk);
    if (ovf) ov_seen++;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Called on the first falling edge after the last input beat is accepted.
  task automatic collect(input bit random_ready);
    int guard;
    bit stalled;
    check("early_valid_c1", 64'(m_valid), 64'd0);
    check("s_ready_in_drain", 64'(s_ready), 64'd0);
    @(negedge clk);
    if (ovf) ov_seen++;
    check("early_valid_c2", 64'(m_valid), 64'd0);
    @(negedge clk);
    check("first_valid_latency", 64'(m_valid), 64'd1);
    guard = 0;
    stalled = 1'b0;
    while (ed.size() > 0 && guard < 2000) begin
      if (ovf) ov_seen++;
      m_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      check("count_in_drain", 64'(n_data), 64'(exp_count));
      if (stalled || !random_ready) check("valid_held", 64'(m_valid), 64'd1);
      if (m_valid) begin
        check("out_data", 64'(m_data), 64'(ed[0]));
        check("out_keep", 64'(m_keep), 64'(ek[0]));
        check("out_last", 64'(m_last), 64'(el[0]));
        if (m_ready) begin
          void'(ed.pop_front()); void'(ek.pop_front()); void'(el.pop_front());
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
        end
      end else begin
        stalled = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    check("drain_remaining", 64'(ed.size()), 64'd0);
    m_ready = 1'b1;
    check("s_ready_after", 64'(s_ready), 64'd1);
    check("valid_after", 64'(m_valid), 64'd0);
    check("count_cleared", 64'(n_data), 64'd0);
  endtask

  task automatic gen_random(input int len);
    vd.delete(); vk.delete();
    for (int i = 0; i < len; i++) begin
      vd.push_back($urandom);
      vk.push_back(2'($urandom_range(0, 3)));
    end
  endtask

  task automatic run_vector(input bit random_ready);
    build_expected();
    send_vector(1'b1);
    collect(random_ready);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_last", 64'(m_last), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_data", 64'(m_data), 64'd0);
    check("rst_keep", 64'(m_keep), 64'd0);
    check("rst_count", 64'(n_data), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(s_ready), 64'd1);

    // Two-beat reference vector, all lanes kept
    vd = '{32'h0300_0100, 32'hFF00_0200};
    vk = '{2'b11, 2'b11};
    run_vector(1'b0);

    // Unkept lane holding the largest value is excluded from max
    vd = '{32'h7FFF_0010, 32'h0001_0005};
    vk = '{2'b01, 2'b11};
    run_vector(1'b0);

    // Saturation, single-beat vector
    vd = '{32'h8000_7FFF};
    vk = '{2'b11};
    run_vector(1'b0);

    // All-zero keep beat is stored and replayed but not counted
    vd = '{32'h1234_FFF0, 32'h7000_7000, 32'h0002_8001};
    vk = '{2'b10, 2'b00, 2'b11};
    run_vector(1'b0);

    // Random vectors, each with full-rate ready then random backpressure
    for (int t = 0; t < 4; t++) begin
      gen_random(int'($urandom_range(1, 12)));
      run_vector(1'b0);
      run_vector(1'b1);
    end

    // Truncation at DEPTH beats, then a fresh vector
    ov_seen = 0;
    gen_random(DP);
    build_expected();
    send_vector(1'b0);
    collect(1'b0);
    check("overflow_pulses", 64'(ov_seen), 64'd1);
    ov_seen = 0;
    gen_random(3);
    run_vector(1'b0);
    check("no_overflow_after", 64'(ov_seen), 64'd0);

    // Reset while the second output beat is presented
    gen_random(4);
    build_expected();
    send_vector(1'b1);
    @(negedge clk);
    @(negedge clk);
    check("rst_drain_beat1_valid", 64'(m_valid), 64'd1);
    @(negedge clk);
    check("rst_drain_beat2_valid", 64'(m_valid), 64'd1);
    check("rst_drain_beat2_data", 64'(m_data), 64'(ed[1]));
    rst_n = 1'b0;
    #1;
    check("rst_drain_valid", 64'(m_valid), 64'd0);
    check("rst_drain_count", 64'(n_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_drain_ready", 64'(s_ready), 64'd1);
    check("rst_drain_no_beat", 64'(m_valid), 64'd0);
    gen_random(5);
    run_vector(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
